// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception controller: SR/Cause/EPC/PRId, take decision, flush then redirect sequencing.
// Latency: take latches state on the edge; FLUSH_CYC flush cycles follow, then one redirect cycle; eret redirects combinationally.
// Backpressure: none; while a flush/redirect sequence is running, new takes, mtc0 and eret are ignored.
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int unsigned FLUSH_CYC    = 2,
  parameter logic [31:0] PRID         = 32'h2017_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_M,
  input  logic [4:0]  ExcM,
  input  logic        ExceptionM,
  input  logic        BD_M,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        we,
  input  logic        eret,
  output logic [31:0] rd_data,
  output logic [31:0] epc_out,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_REDIRECT} state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYC - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;

  // Architectural CP0 fields
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        in_run;
  logic        int_take;
  logic        exc_take;
  logic        take;
  logic        do_eret;
  logic        do_write;
  logic [31:0] pc_aligned;
  logic [31:0] epc_take;
  logic        unused_pc_lsb;

  assign in_run     = (state == S_RUN);
  assign int_take   = in_run & ie & ~exl & (|(HWInt & im));
  assign exc_take   = in_run & ExceptionM & ~exl;
  assign take       = int_take | exc_take;
  assign do_eret    = in_run & eret & ~take;
  assign do_write   = in_run & we & ~take;
  assign pc_aligned = {PC_M[31:2], 2'b00};
  // A delay-slot victim restarts at its branch, one word earlier
  assign epc_take   = BD_M ? (pc_aligned - 32'd4) : pc_aligned;
  assign epc_out    = epc;
  assign unused_pc_lsb = ^PC_M[1:0];

  // Sequencer state and flush counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and pipeline control outputs
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = 32'd0;
    case (state)
      S_RUN: begin
        if (take) begin
          state_nxt = S_FLUSH;
          cnt_nxt   = CNT_INIT;
        end else if (do_eret) begin
          flush       = 1'b1;
          pc_redirect = 1'b1;
          redirect_pc = epc;
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (cnt == 3'd0) state_nxt = S_REDIRECT;
        else             cnt_nxt   = cnt - 3'd1;
      end
      S_REDIRECT: begin
        flush       = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = HANDLER_ADDR;
        state_nxt   = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // CP0 register updates: a take overrides any same-cycle mtc0 or eret
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else if (take) begin
      exl      <= 1'b1;
      bd       <= BD_M;
      epc      <= epc_take;
      exc_code <= int_take ? 5'd0 : ExcM;
    end else begin
      if (do_write) begin
        case (wr_addr)
          5'd12: begin
            im  <= wr_data[15:10];
            exl <= wr_data[1];
            ie  <= wr_data[0];
          end
          5'd14:   epc <= {wr_data[31:2], 2'b00};
          default: ;
        endcase
      end
      if (do_eret) exl <= 1'b0;
    end
  end

  // mfc0 read mux; Cause.IP reflects the live interrupt lines
  always_comb begin
    rd_data = 32'd0;
    case (rd_addr)
      5'd12:   rd_data = {16'd0, im, 8'd0, exl, ie};
      5'd13:   rd_data = {bd, 15'd0, HWInt, 3'd0, exc_code, 2'b00};
      5'd14:   rd_data = epc;
      5'd15:   rd_data = PRID;
      default: rd_data = 32'd0;
    endcase
  end

endmodule
